// File: rtl/rdma_rx_hdr_parser.sv
// RX header parser for IPv4/UDP/RDMA-shim frames on a 32-bit stream.
// Checks the 8-word header, emits metadata, forwards payload or drains and flags rejects.
module rdma_rx_hdr_parser #(
  parameter int unsigned MAX_PAYLOAD = 1472
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic [31:0] i_local_ip,
  input  logic [15:0] i_local_port,
  input  logic [31:0] i_s_tdata,
  input  logic [3:0]  i_s_tkeep,
  input  logic        i_s_tvalid,
  input  logic        i_s_tlast,
  output logic        o_s_tready,
  output logic [15:0] o_meta_payload_len,
  output logic [31:0] o_meta_src_ip,
  output logic [31:0] o_meta_dst_ip,
  output logic [15:0] o_meta_src_port,
  output logic [15:0] o_meta_dst_port,
  output logic [7:0]  o_meta_flags,
  output logic [7:0]  o_meta_endpoint_id,
  output logic        o_meta_valid,
  input  logic        i_meta_ready,
  output logic [31:0] o_m_tdata,
  output logic [3:0]  o_m_tkeep,
  output logic        o_m_tvalid,
  output logic        o_m_tlast,
  input  logic        i_m_tready,
  output logic        o_error,
  output logic [3:0]  o_error_code
);

  localparam int unsigned ACC_W     = 20;
  localparam int unsigned HDR_LAST  = 7;
  localparam int unsigned SHIM_LEN  = 12;
  localparam int unsigned IP_HDR_LEN = 20;

  typedef enum logic [2:0] {
    S_HDR, S_CHECK, S_META, S_PAYLOAD, S_DROP, S_ERR
  } state_t;

  state_t             state;
  logic [2:0]         wcnt;
  logic [ACC_W-1:0]   acc;
  logic               rdy;
  logic               last_w7;
  logic [3:0]         ver;
  logic [3:0]         ihl;
  logic [15:0]        total_len;
  logic [7:0]         proto;
  logic [31:0]        src_ip;
  logic [31:0]        dst_ip;
  logic [15:0]        src_port;
  logic [15:0]        dst_port;
  logic [15:0]        udp_len;
  logic [7:0]         flags;
  logic [7:0]         ep_id;

  logic               in_hs;
  logic [16:0]        fold1;
  logic [16:0]        fold2;
  logic [15:0]        csum;
  logic [15:0]        plen;
  logic [3:0]         chk_code;

  // Input ready is a registered flag except in PAYLOAD, where the sink steers it.
  assign o_s_tready = (state == S_PAYLOAD) ? i_m_tready : rdy;
  assign in_hs      = i_s_tvalid && o_s_tready;

  assign o_m_tvalid = (state == S_PAYLOAD) && i_s_tvalid;
  assign o_m_tdata  = (state == S_PAYLOAD) ? i_s_tdata : '0;
  assign o_m_tkeep  = (state == S_PAYLOAD) ? i_s_tkeep : '0;
  assign o_m_tlast  = (state == S_PAYLOAD) && i_s_tlast;

  // Header checks in priority order; zero means the header is accepted.
  always_comb begin
    fold1    = 17'(acc[15:0]) + 17'(acc[19:16]);
    fold2    = 17'(fold1[15:0]) + 17'(fold1[16]);
    csum     = fold2[15:0];
    plen     = udp_len - 16'(SHIM_LEN);
    chk_code = 4'd0;
    if (last_w7)                                     chk_code = 4'd8;
    else if (ver != 4'd4 || ihl != 4'd5)             chk_code = 4'd1;
    else if (csum != 16'hFFFF)                       chk_code = 4'd9;
    else if (proto != 8'd17)                         chk_code = 4'd2;
    else if (dst_ip != i_local_ip)                   chk_code = 4'd3;
    else if (dst_port != i_local_port)               chk_code = 4'd4;
    else if (udp_len != (total_len - 16'(IP_HDR_LEN))) chk_code = 4'd5;
    else if (udp_len <= 16'(SHIM_LEN))               chk_code = 4'd6;
    else if (plen > 16'(MAX_PAYLOAD))                chk_code = 4'd7;
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      state              <= S_HDR;
      wcnt               <= '0;
      acc                <= '0;
      rdy                <= 1'b0;
      last_w7            <= 1'b0;
      ver                <= '0;
      ihl                <= '0;
      total_len          <= '0;
      proto              <= '0;
      src_ip             <= '0;
      dst_ip             <= '0;
      src_port           <= '0;
      dst_port           <= '0;
      udp_len            <= '0;
      flags              <= '0;
      ep_id              <= '0;
      o_meta_payload_len <= '0;
      o_meta_src_ip      <= '0;
      o_meta_dst_ip      <= '0;
      o_meta_src_port    <= '0;
      o_meta_dst_port    <= '0;
      o_meta_flags       <= '0;
      o_meta_endpoint_id <= '0;
      o_meta_valid       <= 1'b0;
      o_error            <= 1'b0;
      o_error_code       <= '0;
    end else begin
      o_error      <= 1'b0;
      o_error_code <= 4'd0;
      case (state)
        S_HDR: begin
          rdy <= 1'b1;
          if (in_hs) begin
            case (wcnt)
              3'd0: begin
                ver       <= i_s_tdata[31:28];
                ihl       <= i_s_tdata[27:24];
                total_len <= i_s_tdata[15:0];
              end
              3'd2: proto <= i_s_tdata[23:16];
              3'd3: src_ip <= i_s_tdata;
              3'd4: dst_ip <= i_s_tdata;
              3'd5: begin
                src_port <= i_s_tdata[31:16];
                dst_port <= i_s_tdata[15:0];
              end
              3'd6: udp_len <= i_s_tdata[31:16];
              3'd7: begin
                flags <= i_s_tdata[31:24];
                ep_id <= i_s_tdata[23:16];
              end
              default: ;
            endcase
            if (wcnt <= 3'd4)
              acc <= acc + ACC_W'(i_s_tdata[31:16]) + ACC_W'(i_s_tdata[15:0]);
            if (wcnt == 3'(HDR_LAST)) begin
              last_w7 <= i_s_tlast;
              wcnt    <= '0;
              rdy     <= 1'b0;
              state   <= S_CHECK;
            end else if (i_s_tlast) begin
              // Frame ended inside the header: reject immediately.
              wcnt         <= '0;
              acc          <= '0;
              rdy          <= 1'b0;
              o_error      <= 1'b1;
              o_error_code <= 4'd8;
              state        <= S_ERR;
            end else begin
              wcnt <= wcnt + 3'd1;
            end
          end
        end
        S_CHECK: begin
          acc <= '0;
          if (chk_code == 4'd0) begin
            o_meta_valid       <= 1'b1;
            o_meta_payload_len <= plen;
            o_meta_src_ip      <= src_ip;
            o_meta_dst_ip      <= dst_ip;
            o_meta_src_port    <= src_port;
            o_meta_dst_port    <= dst_port;
            o_meta_flags       <= flags;
            o_meta_endpoint_id <= ep_id;
            state              <= S_META;
          end else begin
            o_error      <= 1'b1;
            o_error_code <= chk_code;
            if (last_w7) begin
              state <= S_ERR;
            end else begin
              rdy   <= 1'b1;
              state <= S_DROP;
            end
          end
        end
        S_META: begin
          if (i_meta_ready) begin
            o_meta_valid <= 1'b0;
            state        <= S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          if (i_s_tvalid && i_m_tready && i_s_tlast) begin
            rdy   <= 1'b1;
            state <= S_HDR;
          end
        end
        S_DROP: begin
          if (in_hs && i_s_tlast) state <= S_HDR;
        end
        S_ERR: begin
          rdy   <= 1'b1;
          state <= S_HDR;
        end
        default: begin
          rdy   <= 1'b0;
          state <= S_HDR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rdma_rx_hdr_parser.sv
// Self-checking bench for rdma_rx_hdr_parser: frame vector table driven through a
// stalling source, with metadata/error/payload expectations checked from scoreboard queues.
`timescale 1ns/1ps
module tb_rdma_rx_hdr_parser;

  localparam logic [31:0] LOCAL_IP   = 32'h0A000002;
  localparam logic [15:0] LOCAL_PORT = 16'd4791;
  localparam logic [31:0] SRC_IP     = 32'h0A000001;
  localparam logic [15:0] SRC_PORT   = 16'd5000;
  localparam logic [7:0]  FLAGS      = 8'h5A;
  localparam logic [7:0]  EP         = 8'h03;

  logic        iClk = 1'b0;
  logic        iRst = 1'b0;
  logic [31:0] i_s_tdata = '0;
  logic [3:0]  i_s_tkeep = '0;
  logic        i_s_tvalid = 1'b0;
  logic        i_s_tlast = 1'b0;
  logic        o_s_tready;
  logic [15:0] o_meta_payload_len;
  logic [31:0] o_meta_src_ip, o_meta_dst_ip;
  logic [15:0] o_meta_src_port, o_meta_dst_port;
  logic [7:0]  o_meta_flags, o_meta_endpoint_id;
  logic        o_meta_valid;
  logic        i_meta_ready = 1'b0;
  logic [31:0] o_m_tdata;
  logic [3:0]  o_m_tkeep;
  logic        o_m_tvalid, o_m_tlast;
  logic        i_m_tready = 1'b1;
  logic        o_error;
  logic [3:0]  o_error_code;

  rdma_rx_hdr_parser dut (
    .iClk(iClk), .iRst(iRst),
    .i_local_ip(LOCAL_IP), .i_local_port(LOCAL_PORT),
    .i_s_tdata(i_s_tdata), .i_s_tkeep(i_s_tkeep), .i_s_tvalid(i_s_tvalid),
    .i_s_tlast(i_s_tlast), .o_s_tready(o_s_tready),
    .o_meta_payload_len(o_meta_payload_len),
    .o_meta_src_ip(o_meta_src_ip), .o_meta_dst_ip(o_meta_dst_ip),
    .o_meta_src_port(o_meta_src_port), .o_meta_dst_port(o_meta_dst_port),
    .o_meta_flags(o_meta_flags), .o_meta_endpoint_id(o_meta_endpoint_id),
    .o_meta_valid(o_meta_valid), .i_meta_ready(i_meta_ready),
    .o_m_tdata(o_m_tdata), .o_m_tkeep(o_m_tkeep), .o_m_tvalid(o_m_tvalid),
    .o_m_tlast(o_m_tlast), .i_m_tready(i_m_tready),
    .o_error(o_error), .o_error_code(o_error_code)
  );

  always #5 iClk = ~iClk;

  typedef struct {
    logic [7:0]  ver_ihl;
    logic [7:0]  proto;
    logic [31:0] dst_ip;
    logic [15:0] dst_port;
    logic [15:0] udp_len;
    logic [15:0] tot_adj;
    logic [15:0] csum_xor;
    int          npay;
    int          trunc;
    logic        exp_err;
    logic [3:0]  exp_code;
    logic [15:0] exp_plen;
  } vec_t;

  typedef struct {
    logic        is_err;
    logic [3:0]  code;
    logic [15:0] plen;
    int          lat;
  } ev_t;

  ev_t         ev_q[$];
  logic [32:0] pay_q[$];
  logic [32:0] fq[$];
  vec_t        vecs[14];

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   hdr_end_cyc = 0;
  int   pay_cnt = 0;
  int   meta_stall = 0;
  int   mv_cnt = 0;
  int   mv_cycles = 0;
  logic mtoggle = 1'b0;
  logic abort = 1'b0;
  logic meta_seen = 1'b0;
  logic prev_err = 1'b0;
  ev_t  cur_ev;
  ev_t  mon_ev;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Builds the frame words and pushes the matching expectations.
  task automatic build(input vec_t v, input int seed);
    logic [31:0] w[8];
    logic [15:0] tl;
    logic [31:0] sum;
    logic [15:0] cs;
    int          nwords;
    logic [32:0] e;
    ev_t         ev;
    tl   = v.udp_len + 16'd20 + v.tot_adj;
    w[0] = {v.ver_ihl, 8'h00, tl};
    w[1] = {16'h1234, 16'h4000};
    w[2] = {8'h40, v.proto, 16'h0000};
    w[3] = SRC_IP;
    w[4] = v.dst_ip;
    w[5] = {SRC_PORT, v.dst_port};
    w[6] = {v.udp_len, 16'h0000};
    w[7] = {FLAGS, EP, 16'h0000};
    sum = 32'd0;
    for (int i = 0; i < 5; i++) sum = sum + 32'(w[i][31:16]) + 32'(w[i][15:0]);
    sum = 32'(sum[15:0]) + 32'(sum[31:16]);
    sum = 32'(sum[15:0]) + 32'(sum[31:16]);
    cs = ~sum[15:0];
    w[2][15:0] = cs ^ v.csum_xor;
    nwords = (v.trunc >= 0) ? v.trunc + 1 : 8 + v.npay;
    for (int i = 0; i < nwords; i++) begin
      e[31:0] = (i < 8) ? w[i] : {16'(seed), 16'(i - 8)};
      e[32]   = (i == nwords - 1);
      fq.push_back(e);
      if (!v.exp_err && i >= 8) pay_q.push_back(e);
    end
    ev.is_err = v.exp_err;
    ev.code   = v.exp_code;
    ev.plen   = v.exp_plen;
    ev.lat    = (v.trunc >= 0) ? 0 : 1;
    ev_q.push_back(ev);
  endtask

  // Offers queued words with random valid gaps; records when the header ends.
  task automatic drive_frame();
    int          idx;
    int          guard;
    logic        r;
    logic [32:0] e;
    idx = 0;
    while (fq.size() > 0) begin
      e = fq.pop_front();
      if ($urandom_range(0, 3) == 0) begin
        i_s_tvalid = 1'b0;
        @(posedge iClk); #1;
      end
      i_s_tvalid = 1'b1;
      i_s_tdata  = e[31:0];
      i_s_tkeep  = 4'hF;
      i_s_tlast  = e[32];
      guard = 0;
      r = 1'b0;
      while (!r && guard < 400 && !abort) begin
        @(negedge iClk); r = o_s_tready;
        @(posedge iClk); #1;
        guard++;
      end
      if (abort) begin
        fq.delete();
        break;
      end
      if (!r) begin
        chk("word_accept_timeout", 64'(0), 64'(1));
        fq.delete();
        break;
      end
      if (idx == 7 || (e[32] && idx < 7)) hdr_end_cyc = cyc;
      idx++;
    end
    i_s_tvalid = 1'b0;
    i_s_tlast  = 1'b0;
  endtask

  task automatic drain_and_idle(input string name);
    int guard;
    guard = 0;
    while ((ev_q.size() != 0 || pay_q.size() != 0) && guard < 100) begin
      @(posedge iClk); #1;
      guard++;
    end
    chk({name, "_drain"}, 64'(ev_q.size() + pay_q.size()), 64'(0));
    repeat (2) @(posedge iClk);
    @(negedge iClk);
    chk({name, "_idle_ready"}, 64'({o_s_tready, o_m_tvalid, o_meta_valid}), 64'(3'b100));
    @(posedge iClk); #1;
  endtask

  initial forever begin
    @(posedge iClk);
    cyc++;
  end

  initial forever begin
    @(posedge iClk); #1;
    if (o_meta_valid) begin
      i_meta_ready = (mv_cnt >= meta_stall);
      mv_cnt++;
    end else begin
      mv_cnt = 0;
      i_meta_ready = 1'b0;
    end
    i_m_tready = mtoggle ? ~i_m_tready : 1'b1;
  end

  // Output monitor, sampled mid-cycle.
  always @(negedge iClk) begin
    if (iRst) begin
      if (!o_error) chk("code_idle", 64'(o_error_code), 64'(0));
      if (o_error) begin
        chk("err_width", 64'(prev_err), 64'(0));
        if (ev_q.size() == 0) chk("unexpected_err", 64'(o_error_code), 64'(0));
        else begin
          mon_ev = ev_q.pop_front();
          chk("err_expected", 64'(1), 64'(mon_ev.is_err));
          chk("err_code", 64'(o_error_code), 64'(mon_ev.code));
          chk("err_latency", 64'(cyc - hdr_end_cyc), 64'(mon_ev.lat));
        end
      end
      prev_err = o_error;
      if (o_meta_valid) begin
        if (!meta_seen) begin
          if (ev_q.size() == 0) chk("unexpected_meta", 64'(1), 64'(0));
          else begin
            cur_ev = ev_q.pop_front();
            chk("meta_expected", 64'(cur_ev.is_err), 64'(0));
            chk("meta_latency", 64'(cyc - hdr_end_cyc), 64'(1));
          end
          meta_seen = 1'b1;
          mv_cycles = 0;
        end
        mv_cycles++;
        chk("meta_ips", {o_meta_src_ip, o_meta_dst_ip}, {SRC_IP, LOCAL_IP});
        chk("meta_fields",
            {o_meta_src_port, o_meta_dst_port, o_meta_flags, o_meta_endpoint_id, o_meta_payload_len},
            {SRC_PORT, LOCAL_PORT, FLAGS, EP, cur_ev.plen});
        if (i_meta_ready) begin
          chk("meta_hold_cycles", 64'(mv_cycles), 64'(meta_stall + 1));
          meta_seen = 1'b0;
        end
      end
      if (o_m_tvalid && i_m_tready) begin
        pay_cnt++;
        if (pay_q.size() == 0) chk("unexpected_payload", 64'(o_m_tdata), 64'(0));
        else chk("payload_word", 64'({o_m_tkeep, o_m_tlast, o_m_tdata}),
                 64'({4'hF, pay_q.pop_front()}));
      end
    end
  end

  initial begin
    //                 ver   proto  dst_ip         dport       udp    adj  xor  npay trunc err code plen
    vecs[0]  = '{8'h45, 8'd17, LOCAL_IP,     LOCAL_PORT, 16'd112,  16'd0, 16'h0, 25, -1, 1'b0, 4'd0, 16'd100};
    vecs[1]  = '{8'h45, 8'd17, 32'h0A000009, LOCAL_PORT, 16'd112,  16'd0, 16'h1, 25, -1, 1'b1, 4'd9, 16'd0};
    vecs[2]  = '{8'h46, 8'd17, LOCAL_IP,     LOCAL_PORT, 16'd112,  16'd0, 16'h0,  3, -1, 1'b1, 4'd1, 16'd0};
    vecs[3]  = '{8'h45, 8'd6,  LOCAL_IP,     LOCAL_PORT, 16'd112,  16'd0, 16'h0,  3, -1, 1'b1, 4'd2, 16'd0};
    vecs[4]  = '{8'h45, 8'd17, 32'h0A000003, LOCAL_PORT, 16'd112,  16'd0, 16'h0,  3, -1, 1'b1, 4'd3, 16'd0};
    vecs[5]  = '{8'h45, 8'd17, LOCAL_IP,     16'd4790,   16'd112,  16'd0, 16'h0,  3, -1, 1'b1, 4'd4, 16'd0};
    vecs[6]  = '{8'h45, 8'd17, LOCAL_IP,     LOCAL_PORT, 16'd112,  16'd1, 16'h0,  3, -1, 1'b1, 4'd5, 16'd0};
    vecs[7]  = '{8'h45, 8'd17, LOCAL_IP,     LOCAL_PORT, 16'd12,   16'd0, 16'h0,  2, -1, 1'b1, 4'd6, 16'd0};
    vecs[8]  = '{8'h45, 8'd17, LOCAL_IP,     LOCAL_PORT, 16'd8,    16'd0, 16'h0,  2, -1, 1'b1, 4'd6, 16'd0};
    vecs[9]  = '{8'h45, 8'd17, LOCAL_IP,     LOCAL_PORT, 16'd1485, 16'd0, 16'h0,  3, -1, 1'b1, 4'd7, 16'd0};
    vecs[10] = '{8'h45, 8'd17, LOCAL_IP,     LOCAL_PORT, 16'd1484, 16'd0, 16'h0,  4, -1, 1'b0, 4'd0, 16'd1472};
    vecs[11] = '{8'h45, 8'd17, LOCAL_IP,     LOCAL_PORT, 16'd112,  16'd0, 16'h0, 25,  4, 1'b1, 4'd8, 16'd0};
    vecs[12] = '{8'h45, 8'd17, LOCAL_IP,     LOCAL_PORT, 16'd112,  16'd0, 16'h0,  0, -1, 1'b1, 4'd8, 16'd0};
    vecs[13] = '{8'h45, 8'd17, LOCAL_IP,     LOCAL_PORT, 16'd24,   16'd0, 16'h0,  3, -1, 1'b0, 4'd0, 16'd12};

    #1;
    chk("reset_outputs",
        64'({o_s_tready, o_meta_valid, o_m_tvalid, o_error, o_error_code, o_meta_payload_len,
             o_meta_flags, o_meta_endpoint_id}), 64'(0));
    chk("reset_meta_addr", {o_meta_src_ip, o_meta_dst_ip}, 64'(0));
    chk("reset_meta_ports", 64'({o_meta_src_port, o_meta_dst_port}), 64'(0));
    repeat (2) @(posedge iClk);
    @(negedge iClk);
    iRst = 1'b1;
    #1;
    chk("ready_before_first_edge", 64'(o_s_tready), 64'(0));
    @(negedge iClk);
    chk("ready_after_first_edge", 64'(o_s_tready), 64'(1));
    @(posedge iClk); #1;

    for (int i = 0; i < 14; i++) begin
      build(vecs[i], 16'h100 + i);
      drive_frame();
      drain_and_idle($sformatf("vec%0d", i));
    end

    // Metadata backpressure with a toggling payload sink.
    meta_stall = 5;
    mtoggle    = 1'b1;
    build(vecs[0], 16'h0BB0);
    drive_frame();
    drain_and_idle("backpressure");
    meta_stall = 0;
    mtoggle    = 1'b0;
    @(posedge iClk); #1;

    // Asynchronous reset in the middle of payload forwarding.
    pay_cnt = 0;
    build(vecs[0], 16'h0CC0);
    fork
      drive_frame();
      begin
        int guard;
        guard = 0;
        while (pay_cnt < 5 && guard < 200) begin
          @(posedge iClk);
          guard++;
        end
        chk("reset_test_reached_payload", 64'(pay_cnt >= 5), 64'(1));
        @(negedge iClk); #2;
        iRst  = 1'b0;
        abort = 1'b1;
        #1;
        chk("midframe_reset_outputs",
            64'({o_s_tready, o_meta_valid, o_m_tvalid, o_m_tlast, o_error, o_error_code}), 64'(0));
        chk("midframe_reset_meta", {o_meta_src_ip, o_meta_dst_ip}, 64'(0));
        repeat (3) @(posedge iClk);
      end
    join
    i_s_tvalid = 1'b0;
    ev_q.delete();
    pay_q.delete();
    meta_seen = 1'b0;
    prev_err  = 1'b0;
    @(negedge iClk);
    iRst  = 1'b1;
    abort = 1'b0;
    @(posedge iClk); #1;

    build(vecs[0], 16'h0DD0);
    drive_frame();
    drain_and_idle("after_reset");

    chk("queues_empty", 64'(ev_q.size() + pay_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
